// File: rtl/fifo_stim_driver_pkg.sv
// Shared types and helpers for the FIFO stimulus driver.
//   mode_e    : traffic pattern selected at start (FILL, DRAIN, RANDOM, STRESS)
//   state_e   : run-control FSM states (IDLE, RUN, DONE)
//   LFSR_TAPS : feedback taps 16,14,13,11 of the 16-bit Fibonacci LFSR,
//               expressed as bit positions 0,2,3,5 of a right-shifting register
//   lfsr_step : one LFSR advance (parity of the tapped bits shifted in at the top)
package fifo_stim_driver_pkg;

    typedef enum logic [1:0] {
        MODE_FILL   = 2'd0,
        MODE_DRAIN  = 2'd1,
        MODE_RANDOM = 2'd2,
        MODE_STRESS = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        logic fb_s;
        fb_s = ^(cur & LFSR_TAPS);
        return {fb_s, cur[15:1]};
    endfunction

endpackage

// File: rtl/fifo_stim_driver_lfsr.sv
// stim_lfsr: 16-bit Fibonacci LFSR used as the random source of the driver.
// Ports:
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset, loads SEED
//   load    : reload SEED (has priority over adv)
//   adv     : advance one step
//   want_wr : bit 0 of the current LFSR state
//   want_rd : bit 1 of the current LFSR state
module stim_lfsr
    import fifo_stim_driver_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic adv,
    output logic want_wr,
    output logic want_rd
);

    logic [15:0] lfsr_r;
    logic [15:0] lfsr_nxt_s;

    // Select reload, advance or hold for the LFSR state.
    always_comb begin
        lfsr_nxt_s = lfsr_r;
        if (load) begin
            lfsr_nxt_s = SEED;
        end else if (adv) begin
            lfsr_nxt_s = lfsr_step(lfsr_r);
        end else begin
            lfsr_nxt_s = lfsr_r;
        end
    end

    // LFSR state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_r <= SEED;
        end else begin
            lfsr_r <= lfsr_nxt_s;
        end
    end

    assign want_wr = lfsr_r[0];
    assign want_rd = lfsr_r[1];

endmodule

// File: rtl/fifo_stim_driver.sv
// fifo_stim_driver: traffic generator for the write/read side of a synchronous
// FIFO. A shadow occupancy count keeps the traffic legal and is compared every
// RUN cycle against the FIFO status flags; any disagreement sets a sticky error.
// Ports:
//   clk, rst                : clock and synchronous active-high reset
//   start, mode, num_ops    : run request, traffic mode and run length (latched)
//   full .. underflow,wr_ack: FIFO status inputs
//   wr_en, rd_en, data_in   : registered FIFO requests and write data
//   busy, done              : high in RUN / DONE
//   err_flag                : sticky model/flag mismatch, cleared only by rst
//   wr_count, rd_count      : writes / reads issued in the current run
module fifo_stim_driver
    import fifo_stim_driver_pkg::*;
#(
    parameter int          DATA_WIDTH = 16,
    parameter int          FIFO_DEPTH = 8,
    parameter int          OPS_WIDTH  = 16,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [OPS_WIDTH-1:0]  num_ops,
    input  logic                  full,
    input  logic                  empty,
    input  logic                  almostfull,
    input  logic                  almostempty,
    input  logic                  overflow,
    input  logic                  underflow,
    input  logic                  wr_ack,
    output logic                  wr_en,
    output logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_in,
    output logic                  busy,
    output logic                  done,
    output logic                  err_flag,
    output logic [OPS_WIDTH-1:0]  wr_count,
    output logic [OPS_WIDTH-1:0]  rd_count
);

    localparam int                   OCC_W    = $clog2(FIFO_DEPTH + 1);
    localparam logic [OCC_W-1:0]     DEPTH_C  = OCC_W'(FIFO_DEPTH);
    localparam logic [OCC_W-1:0]     OCC_ZERO = OCC_W'(0);
    localparam logic [OCC_W-1:0]     OCC_ONE  = OCC_W'(1);
    localparam logic [OPS_WIDTH-1:0] OPS_ZERO = OPS_WIDTH'(0);
    localparam logic [OPS_WIDTH-1:0] OPS_ONE  = OPS_WIDTH'(1);

    state_e                state_r,    state_nxt_s;
    mode_e                 mode_r,     mode_nxt_s;
    logic [OPS_WIDTH-1:0]  num_ops_r,  num_ops_nxt_s;
    logic [OPS_WIDTH-1:0]  op_cnt_r,   op_cnt_nxt_s;
    logic [OCC_W-1:0]      occ_r,      occ_nxt_s;
    logic                  wr_en_r,    wr_en_nxt_s;
    logic                  rd_en_r,    rd_en_nxt_s;
    logic [DATA_WIDTH-1:0] data_in_r,  data_in_nxt_s;
    logic [OPS_WIDTH-1:0]  wr_count_r, wr_count_nxt_s;
    logic [OPS_WIDTH-1:0]  rd_count_r, rd_count_nxt_s;
    logic                  busy_r,     busy_nxt_s;
    logic                  done_r,     done_nxt_s;
    logic                  err_r,      err_nxt_s;
    logic                  wr_chk_r,   wr_chk_nxt_s;

    logic [OCC_W-1:0]      occ_upd_s;
    logic [OPS_WIDTH-1:0]  last_op_s;
    logic                  chk_en_s;
    logic                  flag_err_s;
    logic                  lfsr_load_s;
    logic                  lfsr_adv_s;
    logic                  want_wr_s;
    logic                  want_rd_s;

    stim_lfsr #(
        .SEED (SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load    (lfsr_load_s),
        .adv     (lfsr_adv_s),
        .want_wr (want_wr_s),
        .want_rd (want_rd_s)
    );

    assign last_op_s = num_ops_r - OPS_ONE;

    // Occupancy after the requests currently on the bus take effect.
    always_comb begin
        occ_upd_s = occ_r;
        if (wr_en_r && !rd_en_r) begin
            occ_upd_s = occ_r + OCC_ONE;
        end else if (!wr_en_r && rd_en_r) begin
            occ_upd_s = occ_r - OCC_ONE;
        end else begin
            occ_upd_s = occ_r;
        end
    end

    // Compare the FIFO flags against the shadow occupancy; FIFO and model both
    // reflect the same completed edge, so occ_r is the right reference.
    always_comb begin
        chk_en_s   = (state_r == ST_RUN) && (mode_r != MODE_STRESS);
        flag_err_s = (full        != (occ_r == DEPTH_C))
                  || (empty       != (occ_r == OCC_ZERO))
                  || (almostfull  != (occ_r == (DEPTH_C - OCC_ONE)))
                  || (almostempty != (occ_r == OCC_ONE))
                  || overflow
                  || underflow;
        wr_chk_nxt_s = chk_en_s && wr_en_r;
        if (chk_en_s && flag_err_s) begin
            err_nxt_s = 1'b1;
        end else if (wr_chk_r && !wr_ack) begin
            err_nxt_s = 1'b1;
        end else begin
            err_nxt_s = err_r;
        end
    end

    // Run-control FSM, request generation and per-run bookkeeping.
    always_comb begin
        state_nxt_s    = state_r;
        mode_nxt_s     = mode_r;
        num_ops_nxt_s  = num_ops_r;
        op_cnt_nxt_s   = op_cnt_r;
        occ_nxt_s      = occ_r;
        wr_en_nxt_s    = 1'b0;
        rd_en_nxt_s    = 1'b0;
        data_in_nxt_s  = data_in_r;
        wr_count_nxt_s = wr_count_r;
        rd_count_nxt_s = rd_count_r;
        lfsr_load_s    = 1'b0;
        lfsr_adv_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (num_ops != OPS_ZERO) begin
                        state_nxt_s    = ST_RUN;
                        mode_nxt_s     = mode_e'(mode);
                        num_ops_nxt_s  = num_ops;
                        op_cnt_nxt_s   = OPS_ZERO;
                        wr_count_nxt_s = OPS_ZERO;
                        rd_count_nxt_s = OPS_ZERO;
                        lfsr_load_s    = 1'b1;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                lfsr_adv_s = 1'b1;
                // STRESS traffic is unconstrained, so the model is parked at 0.
                if (mode_r == MODE_STRESS) begin
                    occ_nxt_s = OCC_ZERO;
                end else begin
                    occ_nxt_s = occ_upd_s;
                end
                if (op_cnt_r == last_op_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    op_cnt_nxt_s = op_cnt_r + OPS_ONE;
                    case (mode_r)
                        MODE_FILL: begin
                            wr_en_nxt_s = (occ_upd_s < DEPTH_C);
                        end
                        MODE_DRAIN: begin
                            rd_en_nxt_s = (occ_upd_s != OCC_ZERO);
                        end
                        MODE_RANDOM: begin
                            wr_en_nxt_s = want_wr_s && (occ_upd_s < DEPTH_C);
                            rd_en_nxt_s = want_rd_s && (occ_upd_s != OCC_ZERO);
                        end
                        MODE_STRESS: begin
                            wr_en_nxt_s = want_wr_s;
                            rd_en_nxt_s = want_rd_s;
                        end
                        default: begin
                            wr_en_nxt_s = 1'b0;
                            rd_en_nxt_s = 1'b0;
                        end
                    endcase
                end
                // Write data is the index of the write within the run.
                if (wr_en_nxt_s) begin
                    data_in_nxt_s  = DATA_WIDTH'(wr_count_r);
                    wr_count_nxt_s = wr_count_r + OPS_ONE;
                end else begin
                    data_in_nxt_s  = data_in_r;
                    wr_count_nxt_s = wr_count_r;
                end
                if (rd_en_nxt_s) begin
                    rd_count_nxt_s = rd_count_r + OPS_ONE;
                end else begin
                    rd_count_nxt_s = rd_count_r;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        busy_nxt_s = (state_nxt_s == ST_RUN);
        done_nxt_s = (state_nxt_s == ST_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            mode_r     <= MODE_FILL;
            num_ops_r  <= OPS_ZERO;
            op_cnt_r   <= OPS_ZERO;
            occ_r      <= OCC_ZERO;
            wr_en_r    <= 1'b0;
            rd_en_r    <= 1'b0;
            data_in_r  <= DATA_WIDTH'(0);
            wr_count_r <= OPS_ZERO;
            rd_count_r <= OPS_ZERO;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            wr_chk_r   <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            mode_r     <= mode_nxt_s;
            num_ops_r  <= num_ops_nxt_s;
            op_cnt_r   <= op_cnt_nxt_s;
            occ_r      <= occ_nxt_s;
            wr_en_r    <= wr_en_nxt_s;
            rd_en_r    <= rd_en_nxt_s;
            data_in_r  <= data_in_nxt_s;
            wr_count_r <= wr_count_nxt_s;
            rd_count_r <= rd_count_nxt_s;
            busy_r     <= busy_nxt_s;
            done_r     <= done_nxt_s;
            err_r      <= err_nxt_s;
            wr_chk_r   <= wr_chk_nxt_s;
        end
    end

    assign wr_en    = wr_en_r;
    assign rd_en    = rd_en_r;
    assign data_in  = data_in_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign err_flag = err_r;
    assign wr_count = wr_count_r;
    assign rd_count = rd_count_r;

endmodule

// File: tb/tb_fifo_stim_driver.sv
// Directed bench for fifo_stim_driver with a small behavioural FIFO attached.
module tb_fifo_stim_driver;

    localparam int DW = 16;
    localparam int OW = 16;

    logic          clk;
    logic          rst;
    logic          start;
    logic [1:0]    mode;
    logic [OW-1:0] num_ops;
    logic          full, empty, almostfull, almostempty, overflow, underflow, wr_ack;
    logic          wr_en, rd_en, busy, done, err_flag;
    logic [DW-1:0] data_in;
    logic [OW-1:0] wr_count, rd_count;

    // Behavioural depth-8 FIFO: count, registered overflow/underflow/ack pulses.
    logic [3:0] m_cnt;
    logic       m_ovf, m_udf, m_ack;
    logic       m_do_wr, m_do_rd;
    logic       force_full;

    int tests;
    int fails;

    fifo_stim_driver dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mode        (mode),
        .num_ops     (num_ops),
        .full        (full),
        .empty       (empty),
        .almostfull  (almostfull),
        .almostempty (almostempty),
        .overflow    (overflow),
        .underflow   (underflow),
        .wr_ack      (wr_ack),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .data_in     (data_in),
        .busy        (busy),
        .done        (done),
        .err_flag    (err_flag),
        .wr_count    (wr_count),
        .rd_count    (rd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign m_do_wr     = wr_en && (m_cnt != 4'd8);
    assign m_do_rd     = rd_en && (m_cnt != 4'd0);
    assign full        = (m_cnt == 4'd8) || force_full;
    assign empty       = (m_cnt == 4'd0);
    assign almostfull  = (m_cnt == 4'd7);
    assign almostempty = (m_cnt == 4'd1);
    assign overflow    = m_ovf;
    assign underflow   = m_udf;
    assign wr_ack      = m_ack;

    // FIFO model state.
    always @(posedge clk) begin
        if (rst) begin
            m_cnt <= 4'd0;
            m_ovf <= 1'b0;
            m_udf <= 1'b0;
            m_ack <= 1'b0;
        end else begin
            m_cnt <= m_cnt + {3'd0, m_do_wr} - {3'd0, m_do_rd};
            m_ovf <= wr_en && !m_do_wr;
            m_udf <= rd_en && !m_do_rd;
            m_ack <= m_do_wr;
        end
    end

    task automatic do_reset();
        rst   = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Returns just after the edge that accepts start (inside RUN cycle 0).
    task automatic start_run(input logic [1:0] m, input logic [OW-1:0] n);
        @(negedge clk);
        mode    = m;
        num_ops = n;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if ({wr_en, rd_en, busy, done, err_flag} !== 5'b00000) begin
            fails++;
            $display("FAIL reset_ctrl: got %b expected 00000", {wr_en, rd_en, busy, done, err_flag});
        end
        tests++;
        if ({data_in, wr_count, rd_count} !== 48'd0) begin
            fails++;
            $display("FAIL reset_data: got %h/%0d/%0d expected 0/0/0", data_in, wr_count, rd_count);
        end
    endtask

    task automatic test_zero_ops();
        start_run(2'd0, 16'd0);
        @(negedge clk);
        tests++;
        if ({done, busy, wr_en} !== 3'b100) begin
            fails++;
            $display("FAIL zero_ops_done: got done/busy/wr %b expected 100", {done, busy, wr_en});
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || wr_count !== 16'd0) begin
            fails++;
            $display("FAIL zero_ops_idle: got done %b wr_count %0d expected 0 0", done, wr_count);
        end
    endtask

    task automatic test_fill();
        logic exp_wr;
        start_run(2'd0, 16'd10);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            exp_wr = (i >= 1) && (i <= 8);
            tests++;
            if (wr_en !== exp_wr) begin
                fails++;
                $display("FAIL fill_wr_en c%0d: got %b expected %b", i, wr_en, exp_wr);
            end
            if (exp_wr) begin
                tests++;
                if (data_in !== DW'(i - 1)) begin
                    fails++;
                    $display("FAIL fill_data c%0d: got %0d expected %0d", i, data_in, i - 1);
                end
            end
        end
        @(negedge clk);
        tests++;
        if ({done, busy, wr_en, full, err_flag} !== 5'b10010 || wr_count !== 16'd8) begin
            fails++;
            $display("FAIL fill_end: got done/busy/wr/full/err %b wr_count %0d expected 10010 8",
                     {done, busy, wr_en, full, err_flag}, wr_count);
        end
    endtask

    task automatic test_drain();
        logic exp_rd;
        int   udf_seen;
        udf_seen = 0;
        start_run(2'd1, 16'd10);
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            if (m_udf) udf_seen++;
            if (i < 10) begin
                exp_rd = (i >= 1) && (i <= 8);
                tests++;
                if (rd_en !== exp_rd) begin
                    fails++;
                    $display("FAIL drain_rd_en c%0d: got %b expected %b", i, rd_en, exp_rd);
                end
            end
        end
        tests++;
        if ({done, empty, err_flag} !== 3'b110 || rd_count !== 16'd8 || udf_seen != 0) begin
            fails++;
            $display("FAIL drain_end: got done/empty/err %b rd_count %0d underflows %0d expected 110 8 0",
                     {done, empty, err_flag}, rd_count, udf_seen);
        end
    endtask

    task automatic test_random();
        int          bad;
        bit          ok;
        logic [15:0] diff;
        bad = 0;
        ok  = 1'b0;
        start_run(2'd2, 16'd1000);
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            if (m_cnt > 4'd8 || m_ovf || m_udf) bad++;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        tests++;
        if (!ok || bad != 0) begin
            fails++;
            $display("FAIL random_run: done reached %0d illegal cycles %0d expected 1 0", ok, bad);
        end
        diff = wr_count - rd_count;
        tests++;
        if (diff !== {12'd0, m_cnt} || err_flag !== 1'b0 || wr_count == 16'd0) begin
            fails++;
            $display("FAIL random_end: got wr-rd %0d err %b writes %0d expected %0d 0 nonzero",
                     diff, err_flag, wr_count, m_cnt);
        end
    endtask

    // STRESS from empty provokes underflow; STRESS from full provokes overflow.
    task automatic test_stress();
        int udf_seen;
        int ovf_seen;
        bit ok;
        udf_seen = 0;
        ovf_seen = 0;
        do_reset();
        start_run(2'd3, 16'd200);
        for (int i = 0; i < 220; i++) begin
            @(negedge clk);
            if (m_udf) udf_seen++;
            if (done) break;
        end
        tests++;
        if (udf_seen == 0 || err_flag !== 1'b0 || done !== 1'b1) begin
            fails++;
            $display("FAIL stress_empty: got underflows %0d err %b done %b expected >0 0 1", udf_seen, err_flag, done);
        end
        do_reset();
        start_run(2'd0, 16'd10);
        wait_done(20, ok);
        tests++;
        if (!ok || m_cnt !== 4'd8 || err_flag !== 1'b0) begin
            fails++;
            $display("FAIL stress_prefill: got done %0d count %0d err %b expected 1 8 0", ok, m_cnt, err_flag);
        end
        start_run(2'd3, 16'd200);
        for (int i = 0; i < 220; i++) begin
            @(negedge clk);
            if (m_ovf) ovf_seen++;
            if (done) break;
        end
        tests++;
        if (ovf_seen == 0 || err_flag !== 1'b0 || done !== 1'b1) begin
            fails++;
            $display("FAIL stress_full: got overflows %0d err %b done %b expected >0 0 1", ovf_seen, err_flag, done);
        end
    endtask

    task automatic test_flag_force();
        bit ok;
        do_reset();
        start_run(2'd0, 16'd4);
        wait_done(10, ok);
        tests++;
        if (!ok || m_cnt !== 4'd3 || err_flag !== 1'b0) begin
            fails++;
            $display("FAIL force_prefill: got done %0d count %0d err %b expected 1 3 0", ok, m_cnt, err_flag);
        end
        start_run(2'd2, 16'd20);
        @(negedge clk);
        tests++;
        if (busy !== 1'b1 || err_flag !== 1'b0) begin
            fails++;
            $display("FAIL force_pre: got busy %b err %b expected 1 0", busy, err_flag);
        end
        force_full = 1'b1;
        @(negedge clk);
        force_full = 1'b0;
        tests++;
        if (err_flag !== 1'b1) begin
            fails++;
            $display("FAIL force_err_set: got %b expected 1", err_flag);
        end
        wait_done(40, ok);
        tests++;
        if (!ok || err_flag !== 1'b1) begin
            fails++;
            $display("FAIL force_err_done: got done %0d err %b expected 1 1", ok, err_flag);
        end
        start_run(2'd1, 16'd5);
        wait_done(20, ok);
        tests++;
        if (!ok || err_flag !== 1'b1) begin
            fails++;
            $display("FAIL force_err_next_run: got done %0d err %b expected 1 1", ok, err_flag);
        end
        do_reset();
        tests++;
        if (err_flag !== 1'b0) begin
            fails++;
            $display("FAIL force_err_rst: got %b expected 0", err_flag);
        end
    endtask

    task automatic test_mid_reset();
        bit ok;
        start_run(2'd0, 16'd10);
        repeat (7) @(negedge clk);
        tests++;
        if (m_cnt !== 4'd5 || busy !== 1'b1) begin
            fails++;
            $display("FAIL midrst_pre: got count %0d busy %b expected 5 1", m_cnt, busy);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if ({wr_en, rd_en, busy, done} !== 4'b0000 || wr_count !== 16'd0 || rd_count !== 16'd0
            || data_in !== 16'd0 || m_cnt !== 4'd0) begin
            fails++;
            $display("FAIL midrst_state: got wr/rd/busy/done %b counts %0d/%0d data %0d expected 0000 0/0 0",
                     {wr_en, rd_en, busy, done}, wr_count, rd_count, data_in);
        end
        start_run(2'd0, 16'd3);
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (wr_en !== 1'b1 || data_in !== 16'd0) begin
            fails++;
            $display("FAIL midrst_restart: got wr_en %b data %0d expected 1 0", wr_en, data_in);
        end
        wait_done(10, ok);
        tests++;
        if (!ok || wr_count !== 16'd2 || err_flag !== 1'b0) begin
            fails++;
            $display("FAIL midrst_end: got done %0d wr_count %0d err %b expected 1 2 0", ok, wr_count, err_flag);
        end
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        rst        = 1'b1;
        start      = 1'b0;
        mode       = 2'd0;
        num_ops    = 16'd0;
        force_full = 1'b0;
        test_reset();
        test_zero_ops();
        test_fill();
        test_drain();
        test_random();
        test_stress();
        test_flag_force();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, %0d tests run", tests);
        $fatal(1);
    end

endmodule
